// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
//   Feeds the four digit inputs of the seven-segment display driver and
//   holds the last result stable between conversions.
//
// Handshake: a request is accepted on a rising edge where start = 1 and the
//   FSM is in IDLE (busy = 0). While busy = 1, start is ignored, not queued.
//   busy is high from the accept edge until the final shift step. On the
//   final step, done pulses for one cycle and busy is low. A new start may
//   therefore be presented in the done cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   conversion request (sampled only in IDLE)
//   bin    in   W-bit unsigned value, captured on accept
//   d3..d0 out  BCD thousands/hundreds/tens/ones, registered
//   busy   out  conversion in progress
//   done   out  one-cycle pulse when d3..d0/ovf update
//   ovf    out  last converted value exceeded 9999 (shown as 9999)
module bin_to_bcd_seq #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic [3:0]   d3,
  output logic [3:0]   d2,
  output logic [3:0]   d1,
  output logic [3:0]   d0,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // FSM state, kept as a named signal so checkers can bind to it.
  logic [0:0]   state;
  logic [W-1:0] bin_work;
  logic [15:0]  bcd;
  logic [3:0]   cnt;
  logic         ovf_pend;

  logic [13:0]  bin_ext;
  logic         ovf_in;
  logic [W-1:0] bin_cap;
  logic [15:0]  bcd_adj;
  logic [15:0]  bcd_next;

  // Only a 14-bit input can exceed 9999; narrower inputs top out at 8191.
  assign bin_ext = 14'(bin);
  assign ovf_in  = (W == 14) && (bin_ext > 14'd9999);
  assign bin_cap = ovf_in ? W'(14'd9999) : bin;

  // Add 3 to every nibble >= 5 (no carry between nibbles), then shift the
  // next binary bit into the BCD accumulator.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[14:0], bin_work[W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bin_work <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      d3       <= '0;
      d2       <= '0;
      d1       <= '0;
      d0       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bin_work <= bin_cap;
            bcd      <= '0;
            cnt      <= 4'(W);
            ovf_pend <= ovf_in;
            busy     <= 1'b1;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd      <= bcd_next;
          bin_work <= {bin_work[W-2:0], 1'b0};
          cnt      <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Final step: publish the post-step digits in one update.
            d3    <= bcd_next[15:12];
            d2    <= bcd_next[11:8];
            d1    <= bcd_next[7:4];
            d0    <= bcd_next[3:0];
            ovf   <= ovf_pend;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int W = 14;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic [3:0]   d3, d2, d1, d0;
  logic         busy;
  logic         done;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called at a negedge; presents start for one rising edge (edge k) and
  // returns at the negedge following edge k.
  task automatic launch(input logic [W-1:0] v);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after edge k. lat = number of edges after k at
  // which done was first seen; bc = busy samples seen (edge k included);
  // both = done and busy seen high together.
  task automatic wait_done(output int lat, output int bc, output bit to, output bit both);
    lat  = 0;
    to   = 1'b1;
    both = 1'b0;
    bc   = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 && busy === 1'b1) both = 1'b1;
      if (done === 1'b1) begin
        lat = i;
        to  = 1'b0;
        break;
      end
      if (busy === 1'b1) bc++;
    end
  endtask

  function automatic logic [15:0] to_dec(input int v);
    to_dec = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got d=%h busy=%b done=%b ovf=%b, want d=0000 busy=0 done=0 ovf=0",
               {d3, d2, d1, d0}, busy, done, ovf);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    bit to, both;
    launch(14'd0);
    wait_done(lat, bc, to, both);
    checks++;
    if (to || lat != 14) begin
      errors++;
      $display("FAIL zero_latency: got %0d (timeout=%0b), want 14", lat, to);
    end
    checks++;
    if (bc != 14) begin
      errors++;
      $display("FAIL zero_busy_cycles: got %0d, want 14", bc);
    end
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0000 || ovf !== 1'b0 || both) begin
      errors++;
      $display("FAIL zero_result: got d=%h ovf=%b both=%0b, want d=0000 ovf=0 both=0",
               {d3, d2, d1, d0}, ovf, both);
    end
  endtask

  task automatic test_hold();
    int lat, bc, extra_done;
    bit to, both, moved;
    launch(14'd1234);
    wait_done(lat, bc, to, both);
    checks++;
    if (to || {d3, d2, d1, d0} !== 16'h1234 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL conv_1234: got d=%h ovf=%b timeout=%0b, want d=1234 ovf=0",
               {d3, d2, d1, d0}, ovf, to);
    end
    extra_done = 0;
    moved      = 1'b0;
    bin        = 14'd777;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      if ({d3, d2, d1, d0} !== 16'h1234) moved = 1'b1;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL done_single_cycle: got %0d extra done cycles, want 0", extra_done);
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL hold_1234: got digits changing while idle, want stable 1234");
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc;
    bit to, both;
    launch(14'd9999);
    wait_done(lat1, bc, to, both);
    checks++;
    if (to || {d3, d2, d1, d0} !== 16'h9999 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL conv_9999: got d=%h ovf=%b timeout=%0b, want d=9999 ovf=0",
               {d3, d2, d1, d0}, ovf, to);
    end
    // Still in the done cycle: this start must be accepted at edge k+15.
    launch(14'd12000);
    wait_done(lat2, bc, to, both);
    checks++;
    if (to || (lat1 + 1 + lat2) != 29) begin
      errors++;
      $display("FAIL b2b_latency: got done at k+%0d, want k+29", lat1 + 1 + lat2);
    end
    checks++;
    if ({d3, d2, d1, d0} !== 16'h9999 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL conv_12000_ovf: got d=%h ovf=%b, want d=9999 ovf=1", {d3, d2, d1, d0}, ovf);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc, extra_done;
    bit to, both;
    launch(14'd5678);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd42;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, to, both);
    checks++;
    if (to || lat != 9) begin
      errors++;
      $display("FAIL busy_start_latency: got done %0d edges after retry (timeout=%0b), want 9", lat, to);
    end
    checks++;
    if ({d3, d2, d1, d0} !== 16'h5678 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL conv_5678: got d=%h ovf=%b, want d=5678 ovf=0", {d3, d2, d1, d0}, ovf);
    end
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL busy_start_queued: got %0d busy/done cycles after result, want 0", extra_done);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen;
    bit to, both;
    launch(14'd4321);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got d=%h busy=%b done=%b ovf=%b, want d=0000 busy=0 done=0 ovf=0",
               {d3, d2, d1, d0}, busy, done, ovf);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", seen);
    end
    launch(14'd807);
    wait_done(lat, bc, to, both);
    checks++;
    if (to || {d3, d2, d1, d0} !== 16'h0807) begin
      errors++;
      $display("FAIL conv_807: got d=%h timeout=%0b, want d=0807", {d3, d2, d1, d0}, to);
    end
  endtask

  task automatic test_sweep();
    int lat, bc, bad;
    bit to, both;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int v;
    bad = 0;
    v   = 0;
    while (v <= 9999) begin
      exp_q.push_back(to_dec(v));
      launch(14'(v));
      wait_done(lat, bc, to, both);
      exp_v = exp_q.pop_front();
      checks++;
      if (to || both || {d3, d2, d1, d0} !== exp_v || ovf !== 1'b0 ||
          d3 > 4'd9 || d2 > 4'd9 || d1 > 4'd9 || d0 > 4'd9) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep_%0d: got d=%h ovf=%b timeout=%0b, want d=%h ovf=0",
                   v, {d3, d2, d1, d0}, ovf, to, exp_v);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (v == 9999) break;
      v = (v + 13 > 9999) ? 9999 : v + 13;
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_hold();
    test_back_to_back();
    test_start_while_busy();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
